// File: rtl/udp_win_packer.sv
// udp_win_packer: frame decimation, X/Y window crop, pixel packing, word FIFO
// and UDP packet request generation on a single clock domain.
module udp_win_packer #(
  parameter int PIX_W     = 16,
  parameter int PACK      = 2,
  parameter int FRM_DIV   = 2,
  parameter int H_ACT     = 1280,
  parameter int V_ACT     = 960,
  parameter int X0        = 160,
  parameter int X1        = 1120,
  parameter int Y0        = 210,
  parameter int Y1        = 750,
  parameter int DEPTH     = 2048,
  parameter int PKT_WORDS = 480
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          vs,
  input  logic                          de,
  input  logic [PIX_W-1:0]              din,
  input  logic                          rd_en,
  output logic [PIX_W*PACK-1:0]         rd_data,
  output logic                          rd_vld,
  output logic                          pkt_req,
  output logic [15:0]                   pkt_len,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          ovf_err,
  output logic                          udf_err
);

  localparam int W  = PIX_W * PACK;
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = (FRM_DIV > 1) ? $clog2(FRM_DIV) : 1;
  localparam int CW = $clog2(H_ACT + 1);
  localparam int RW = $clog2(V_ACT + 1);
  localparam int PW = (PACK > 1) ? $clog2(PACK) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, SEND = 2'd2} state_t;

  logic [W-1:0]  mem [DEPTH];
  logic          vs_d_r, frm_keep_r, win_done_r;
  logic [FW-1:0] frm_cnt_r;
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;
  logic [PW-1:0] pk_cnt_r;
  logic [W-1:0]  pk_buf_r, rd_data_r;
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [LW-1:0] level_r;
  logic          rd_vld_r, ovf_err_r, udf_err_r, pkt_req_r;
  logic [15:0]   pkt_len_r, remain_r;
  state_t        state_r, state_nx_s;
  logic [15:0]   pkt_len_nx_s, remain_nx_s;
  logic          pkt_req_nx_s;

  // Frame start is a vs rising edge; de is ignored while vs is high.
  logic          fs_s, de_s, in_win_s, accept_s, push_s, pop_s, wr_ok_s, win_last_s;
  logic [W-1:0]  word_s;

  assign fs_s       = vs & ~vs_d_r;
  assign de_s       = de & ~vs;
  assign in_win_s   = (col_r >= CW'(X0)) && (col_r < CW'(X1)) &&
                      (row_r >= RW'(Y0)) && (row_r < RW'(Y1));
  assign accept_s   = frm_keep_r & de_s & in_win_s;
  // Earlier pixels shift toward the MS slot, the newest pixel takes the LS slot.
  assign word_s     = (pk_buf_r << PIX_W) | W'(din);
  assign push_s     = accept_s & (pk_cnt_r == PW'(PACK - 1));
  assign pop_s      = rd_en & (level_r != {LW{1'b0}}) & ~fs_s;
  // A full FIFO still takes a word when the same cycle frees a slot.
  assign wr_ok_s    = push_s & ((level_r != LW'(DEPTH)) | pop_s) & ~fs_s;
  assign win_last_s = accept_s && (col_r == CW'(X1 - 1)) && (row_r == RW'(Y1 - 1));

  // FIFO storage write port (no reset needed on the data array).
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem[wr_ptr_r] <= word_s;
    end
  end

  // Frame/raster tracking, packing, FIFO pointers, read port and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vs_d_r     <= 1'b0;
      frm_cnt_r  <= {FW{1'b0}};
      frm_keep_r <= 1'b0;
      col_r      <= {CW{1'b0}};
      row_r      <= {RW{1'b0}};
      pk_cnt_r   <= {PW{1'b0}};
      pk_buf_r   <= {W{1'b0}};
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      level_r    <= {LW{1'b0}};
      rd_data_r  <= {W{1'b0}};
      rd_vld_r   <= 1'b0;
      win_done_r <= 1'b0;
      ovf_err_r  <= 1'b0;
      udf_err_r  <= 1'b0;
    end else begin
      vs_d_r <= vs;
      if (fs_s) begin
        frm_keep_r <= (frm_cnt_r == {FW{1'b0}});
        frm_cnt_r  <= (frm_cnt_r == FW'(FRM_DIV - 1)) ? {FW{1'b0}} : frm_cnt_r + FW'(1);
        col_r      <= {CW{1'b0}};
        row_r      <= {RW{1'b0}};
        pk_cnt_r   <= {PW{1'b0}};
        pk_buf_r   <= {W{1'b0}};
        wr_ptr_r   <= {AW{1'b0}};
        rd_ptr_r   <= {AW{1'b0}};
        level_r    <= {LW{1'b0}};
        rd_vld_r   <= 1'b0;
        win_done_r <= 1'b0;
      end else begin
        if (de_s) begin
          if (col_r == CW'(H_ACT - 1)) begin
            col_r <= {CW{1'b0}};
            row_r <= (row_r == RW'(V_ACT - 1)) ? {RW{1'b0}} : row_r + RW'(1);
          end else begin
            col_r <= col_r + CW'(1);
          end
        end
        if (accept_s) begin
          pk_buf_r <= word_s;
          pk_cnt_r <= push_s ? {PW{1'b0}} : pk_cnt_r + PW'(1);
        end
        if (wr_ok_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r  <= rd_ptr_r + AW'(1);
          rd_data_r <= mem[rd_ptr_r];
        end
        rd_vld_r <= pop_s;
        level_r  <= level_r + LW'(wr_ok_s) - LW'(pop_s);
        if (win_last_s) begin
          win_done_r <= 1'b1;
        end
      end
      if (push_s && !wr_ok_s) begin
        ovf_err_r <= 1'b1;
      end
      if (rd_en && (level_r == {LW{1'b0}})) begin
        udf_err_r <= 1'b1;
      end
    end
  end

  // Packet FSM state register; pkt_req/pkt_len are registered from next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      pkt_req_r <= 1'b0;
      pkt_len_r <= 16'd0;
      remain_r  <= 16'd0;
    end else begin
      state_r   <= state_nx_s;
      pkt_req_r <= pkt_req_nx_s;
      pkt_len_r <= pkt_len_nx_s;
      remain_r  <= remain_nx_s;
    end
  end

  // Packet FSM next state: full packet, end-of-window tail, pop counting, frame abort.
  always_comb begin
    state_nx_s   = state_r;
    pkt_len_nx_s = pkt_len_r;
    remain_nx_s  = remain_r;
    if (fs_s) begin
      state_nx_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (level_r >= LW'(PKT_WORDS)) begin
            state_nx_s   = REQ;
            pkt_len_nx_s = 16'(PKT_WORDS);
          end else if (win_done_r && (level_r != {LW{1'b0}})) begin
            state_nx_s   = REQ;
            pkt_len_nx_s = 16'(level_r);
          end else begin
            state_nx_s = IDLE;
          end
        end
        REQ: begin
          if (pop_s) begin
            state_nx_s  = (pkt_len_r == 16'd1) ? IDLE : SEND;
            remain_nx_s = pkt_len_r - 16'd1;
          end else begin
            state_nx_s = REQ;
          end
        end
        SEND: begin
          if (remain_r == 16'd0) begin
            state_nx_s = IDLE;
          end else if (pop_s) begin
            remain_nx_s = remain_r - 16'd1;
            state_nx_s  = (remain_r == 16'd1) ? IDLE : SEND;
          end else begin
            state_nx_s = SEND;
          end
        end
        default: begin
          state_nx_s = IDLE;
        end
      endcase
    end
  end

  // Packet FSM outputs: request is held in every non-idle state.
  always_comb begin
    pkt_req_nx_s = 1'b0;
    if (state_nx_s != IDLE) begin
      pkt_req_nx_s = 1'b1;
    end else begin
      pkt_req_nx_s = 1'b0;
    end
  end

  assign rd_data = rd_data_r;
  assign rd_vld  = rd_vld_r;
  assign pkt_req = pkt_req_r;
  assign pkt_len = pkt_len_r;
  assign level   = level_r;
  assign ovf_err = ovf_err_r;
  assign udf_err = udf_err_r;

endmodule

// File: tb/tb_udp_win_packer.sv
// Scoreboard bench for udp_win_packer on an 8x6 raster, window cols 2..5,
// rows 1..4 (8 words per kept frame), DEPTH=4, PKT_WORDS=3, FRM_DIV=2.
module tb_udp_win_packer;

  logic        clk = 1'b0;
  logic        rst, vs, de, rd_en;
  logic [15:0] din;
  logic [31:0] rd_data;
  logic        rd_vld, pkt_req, ovf_err, udf_err;
  logic [15:0] pkt_len;
  logic [2:0]  level;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_words[$];
  logic [15:0] exp_lens[$];
  logic        pkt_req_q;

  udp_win_packer #(
    .PIX_W(16), .PACK(2), .FRM_DIV(2), .H_ACT(8), .V_ACT(6),
    .X0(2), .X1(6), .Y0(1), .Y1(5), .DEPTH(4), .PKT_WORDS(3)
  ) dut (
    .clk(clk), .rst(rst), .vs(vs), .de(de), .din(din), .rd_en(rd_en),
    .rd_data(rd_data), .rd_vld(rd_vld), .pkt_req(pkt_req), .pkt_len(pkt_len),
    .level(level), .ovf_err(ovf_err), .udf_err(udf_err)
  );

  always #5 clk = ~clk;

  // Window word h (0/1) of row r with din = 16*row + col.
  function automatic logic [31:0] w(int r, int h);
    logic [15:0] a;
    a = 16'(16 * r + 2 + 2 * h);
    return {a, a + 16'd1};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc;
    @(negedge clk);
  endtask

  task automatic frame_start;
    vs = 1'b1; de = 1'b0; rd_en = 1'b0;
    cyc; cyc;
    vs = 1'b0;
    cyc;
  endtask

  // One raster line; optional pops on columns pa/pb with their expected words.
  task automatic feed_line(int r, int pa, int pb, logic [31:0] ea, logic [31:0] eb);
    for (int c = 0; c < 8; c++) begin
      de = 1'b1;
      din = 16'(16 * r + c);
      rd_en = (c == pa) || (c == pb);
      if (c == pa) exp_words.push_back(ea);
      if (c == pb) exp_words.push_back(eb);
      cyc;
    end
    de = 1'b0; rd_en = 1'b0;
    cyc; cyc; cyc;
  endtask

  task automatic feed_plain(int r);
    feed_line(r, -1, -1, 32'd0, 32'd0);
  endtask

  task automatic pop(logic [31:0] e);
    exp_words.push_back(e);
    rd_en = 1'b1;
    cyc;
    rd_en = 1'b0;
    cyc;
  endtask

  // Kept frame read out packet by packet: 3, 3, then a 2-word tail.
  task automatic clean_frame;
    exp_lens.push_back(16'd3); exp_lens.push_back(16'd3); exp_lens.push_back(16'd2);
    frame_start;
    feed_plain(0); feed_plain(1); feed_plain(2);
    check("level_after_rows12", 32'(level), 32'd4);
    pop(w(1, 0)); pop(w(1, 1)); pop(w(2, 0));
    feed_plain(3);
    pop(w(2, 1)); pop(w(3, 0)); pop(w(3, 1));
    feed_plain(4);
    pop(w(4, 0)); pop(w(4, 1));
    feed_plain(5);
    check("level_end_clean", 32'(level), 32'd0);
  endtask

  task automatic dropped_frame;
    frame_start;
    for (int r = 0; r < 6; r++) feed_plain(r);
    check("level_dropped", 32'(level), 32'd0);
    check("pkt_req_dropped", 32'(pkt_req), 32'd0);
  endtask

  // Monitor: compares popped words and each new packet request against the queues.
  always @(negedge clk) begin
    if (rst) begin
      pkt_req_q <= 1'b0;
    end else begin
      if (rd_vld) begin
        if (exp_words.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rd_data_unexpected: got %h expected none", rd_data);
        end else begin
          check("rd_data", rd_data, exp_words.pop_front());
        end
      end
      if (pkt_req && !pkt_req_q) begin
        if (exp_lens.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL pkt_req_unexpected: got pkt_len %0d expected none", pkt_len);
        end else begin
          check("pkt_len", 32'(pkt_len), 32'(exp_lens.pop_front()));
        end
      end
      pkt_req_q <= pkt_req;
    end
  end

  initial begin
    rst = 1'b1; vs = 1'b0; de = 1'b0; rd_en = 1'b0; din = 16'd0;
    cyc; cyc;
    rst = 1'b0;
    cyc;
    check("rst_level", 32'(level), 32'd0);
    check("rst_pkt_req", 32'(pkt_req), 32'd0);
    check("rst_pkt_len", 32'(pkt_len), 32'd0);
    check("rst_rd_vld", 32'(rd_vld), 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    check("rst_udf", 32'(udf_err), 32'd0);

    // Frame 1 kept, frame 2 dropped.
    clean_frame;
    dropped_frame;

    // Frame 3: fill to DEPTH, push+pop while full, then overflow and drain.
    exp_lens.push_back(16'd3); exp_lens.push_back(16'd3);
    frame_start;
    feed_plain(0); feed_plain(1); feed_plain(2);
    check("level_full", 32'(level), 32'd4);
    feed_line(3, 3, 5, w(1, 0), w(1, 1));
    check("level_pushpop_full", 32'(level), 32'd4);
    check("ovf_pushpop_full", 32'(ovf_err), 32'd0);
    feed_plain(4);
    check("level_after_ovf", 32'(level), 32'd4);
    check("ovf_set", 32'(ovf_err), 32'd1);
    pop(w(2, 0)); pop(w(2, 1)); pop(w(3, 0)); pop(w(3, 1));
    check("level_drained", 32'(level), 32'd0);
    check("udf_before", 32'(udf_err), 32'd0);
    rd_en = 1'b1;
    cyc;
    rd_en = 1'b0;
    check("rd_vld_on_empty", 32'(rd_vld), 32'd0);
    check("udf_set", 32'(udf_err), 32'd1);
    cyc;

    // Frame 4 dropped; frame 5 aborted mid-SEND by frame 6's start.
    dropped_frame;
    exp_lens.push_back(16'd3);
    frame_start;
    feed_plain(0); feed_plain(1); feed_plain(2);
    pop(w(1, 0));
    check("pkt_req_in_send", 32'(pkt_req), 32'd1);
    vs = 1'b1; rd_en = 1'b1;
    cyc;
    rd_en = 1'b0;
    check("abort_level", 32'(level), 32'd0);
    check("abort_pkt_req", 32'(pkt_req), 32'd0);
    check("abort_rd_vld", 32'(rd_vld), 32'd0);
    cyc;
    vs = 1'b0;
    cyc;

    // Frame 6 dropped (no pixels), frame 7 kept and restarts cleanly.
    clean_frame;
    cyc; cyc;
    check("ovf_sticky", 32'(ovf_err), 32'd1);
    check("udf_sticky", 32'(udf_err), 32'd1);
    check("words_left", 32'(exp_words.size()), 32'd0);
    check("lens_left", 32'(exp_lens.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
